// File: rtl/multicycle_control_fsm_if.sv
// Unified instruction/data memory handshake between the control FSM and memory.
// master: drives mem_req, mem_write, adr_src; samples mem_ready. slave: the reverse.
interface multicycle_control_fsm_if;
  logic mem_req;
  logic mem_write;
  logic adr_src;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_write,
    output adr_src,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_write,
    input  adr_src,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle RV32I main control FSM: fetch/decode/execute/mem/writeback sequencing.
// Ports: clk, reset, opcode, funct3, alu_zero, mem (memory handshake), datapath controls, trap.
module multicycle_control_fsm (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [6:0]                      opcode,
  input  logic [2:0]                      funct3,
  input  logic                            alu_zero,
  multicycle_control_fsm_if.master        mem,
  output logic                            ir_write,
  output logic                            pc_write,
  output logic                            reg_write,
  output logic [1:0]                      alu_src_a,
  output logic [1:0]                      alu_src_b,
  output logic [1:0]                      result_src,
  output logic [2:0]                      imm_src,
  output logic [1:0]                      alu_op,
  output logic                            is_imm,
  output logic                            trap
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD,
    MEMWB, MEMWRITE, EXECR, EXECI,
    ALUWB, BRANCH, JAL, JALR,
    JALR_LINK, LUI, AUIPC, TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  state_t state, state_n;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_n;
  end

  always_comb begin
    state_n       = state;
    mem.mem_req   = 1'b0;
    mem.mem_write = 1'b0;
    mem.adr_src   = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    result_src    = 2'b00;
    imm_src       = IMM_I;
    alu_op        = 2'b00;
    is_imm        = 1'b0;
    trap          = 1'b0;
    // Reset forces every output low; the register reloads FETCH.
    if (!reset) begin
      unique case (state)
        FETCH: begin
          mem.mem_req = 1'b1;
          if (mem.mem_ready) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            state_n    = DECODE;
          end
        end
        DECODE: begin
          // Branch/jump target lands in the ALU-out register.
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
          imm_src   = (opcode == OP_JAL) ? IMM_J : IMM_B;
          case (opcode)
            OP_LOAD,
            OP_STORE: state_n = MEMADR;
            OP_R:     state_n = EXECR;
            OP_I:     state_n = EXECI;
            OP_BR:    state_n = BRANCH;
            OP_JAL:   state_n = JAL;
            OP_JALR:  state_n = JALR;
            OP_LUI:   state_n = LUI;
            OP_AUIPC: state_n = AUIPC;
            default:  state_n = TRAP;
          endcase
        end
        MEMADR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          if (opcode == OP_STORE) begin
            imm_src = IMM_S;
            state_n = MEMWRITE;
          end else begin
            imm_src = IMM_I;
            state_n = MEMREAD;
          end
        end
        MEMREAD: begin
          mem.mem_req = 1'b1;
          mem.adr_src = 1'b1;
          if (mem.mem_ready) state_n = MEMWB;
        end
        MEMWB: begin
          result_src = 2'b01;
          reg_write  = 1'b1;
          state_n    = FETCH;
        end
        MEMWRITE: begin
          mem.mem_req   = 1'b1;
          mem.mem_write = 1'b1;
          mem.adr_src   = 1'b1;
          if (mem.mem_ready) state_n = FETCH;
        end
        EXECR: begin
          alu_src_a = 2'b10;
          alu_op    = 2'b10;
          state_n   = ALUWB;
        end
        EXECI: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          imm_src   = IMM_I;
          alu_op    = 2'b10;
          is_imm    = 1'b1;
          state_n   = ALUWB;
        end
        ALUWB: begin
          reg_write = 1'b1;
          state_n   = FETCH;
        end
        BRANCH: begin
          // BEQ tests for zero; every other compare yields nonzero when true.
          alu_src_a = 2'b10;
          alu_op    = 2'b01;
          pc_write  = (funct3 == 3'b000) ? alu_zero : !alu_zero;
          state_n   = FETCH;
        end
        JAL: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          pc_write  = 1'b1;
          state_n   = ALUWB;
        end
        JALR: begin
          alu_src_a  = 2'b10;
          alu_src_b  = 2'b01;
          imm_src    = IMM_I;
          result_src = 2'b10;
          pc_write   = 1'b1;
          state_n    = JALR_LINK;
        end
        JALR_LINK: begin
          // rs1 was consumed last cycle, so rd == rs1 is safe.
          alu_src_a  = 2'b01;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
          reg_write  = 1'b1;
          state_n    = FETCH;
        end
        LUI: begin
          alu_src_a  = 2'b11;
          alu_src_b  = 2'b01;
          imm_src    = IMM_U;
          result_src = 2'b10;
          reg_write  = 1'b1;
          state_n    = FETCH;
        end
        AUIPC: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
          imm_src   = IMM_U;
          state_n   = ALUWB;
        end
        TRAP: begin
          trap = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed testbench for multicycle_control_fsm.
// Each task walks one instruction class and compares all outputs per cycle.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       alu_zero;
  logic       ir_write, pc_write, reg_write;
  logic [1:0] alu_src_a, alu_src_b, result_src, alu_op;
  logic [2:0] imm_src;
  logic       is_imm, trap;

  int checks = 0;
  int failures = 0;

  multicycle_control_fsm_if mem_bus ();

  multicycle_control_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .funct3     (funct3),
    .alu_zero   (alu_zero),
    .mem        (mem_bus),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .result_src (result_src),
    .imm_src    (imm_src),
    .alu_op     (alu_op),
    .is_imm     (is_imm),
    .trap       (trap)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] mk(
    input logic mr, mw, ad, iw, pw, rw,
    input logic [1:0] a, b, rs,
    input logic [2:0] im,
    input logic [1:0] op,
    input logic ii, tr
  );
    return {mr, mw, ad, iw, pw, rw, a, b, rs, im, op, ii, tr};
  endfunction

  function automatic logic [18:0] outs();
    return {mem_bus.mem_req, mem_bus.mem_write, mem_bus.adr_src,
            ir_write, pc_write, reg_write,
            alu_src_a, alu_src_b, result_src,
            imm_src, alu_op, is_imm, trap};
  endfunction

  localparam logic [18:0] ZERO = '0;
  localparam logic [18:0] FW  = mk(1,0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0,0);
  localparam logic [18:0] FR  = mk(1,0,0,1,1,0,2'b00,2'b10,2'b10,3'b000,2'b00,0,0);
  localparam logic [18:0] DB  = mk(0,0,0,0,0,0,2'b01,2'b01,2'b00,3'b010,2'b00,0,0);
  localparam logic [18:0] DJ  = mk(0,0,0,0,0,0,2'b01,2'b01,2'b00,3'b011,2'b00,0,0);
  localparam logic [18:0] MAL = mk(0,0,0,0,0,0,2'b10,2'b01,2'b00,3'b000,2'b00,0,0);
  localparam logic [18:0] MAS = mk(0,0,0,0,0,0,2'b10,2'b01,2'b00,3'b001,2'b00,0,0);
  localparam logic [18:0] MR  = mk(1,0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0,0);
  localparam logic [18:0] MWB = mk(0,0,0,0,0,1,2'b00,2'b00,2'b01,3'b000,2'b00,0,0);
  localparam logic [18:0] MW  = mk(1,1,1,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0,0);
  localparam logic [18:0] EXR = mk(0,0,0,0,0,0,2'b10,2'b00,2'b00,3'b000,2'b10,0,0);
  localparam logic [18:0] EXI = mk(0,0,0,0,0,0,2'b10,2'b01,2'b00,3'b000,2'b10,1,0);
  localparam logic [18:0] AWB = mk(0,0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,2'b00,0,0);
  localparam logic [18:0] BRN = mk(0,0,0,0,0,0,2'b10,2'b00,2'b00,3'b000,2'b01,0,0);
  localparam logic [18:0] BRT = mk(0,0,0,0,1,0,2'b10,2'b00,2'b00,3'b000,2'b01,0,0);
  localparam logic [18:0] JL  = mk(0,0,0,0,1,0,2'b01,2'b10,2'b00,3'b000,2'b00,0,0);
  localparam logic [18:0] JR  = mk(0,0,0,0,1,0,2'b10,2'b01,2'b10,3'b000,2'b00,0,0);
  localparam logic [18:0] JRL = mk(0,0,0,0,0,1,2'b01,2'b10,2'b10,3'b000,2'b00,0,0);
  localparam logic [18:0] LU  = mk(0,0,0,0,0,1,2'b11,2'b01,2'b10,3'b100,2'b00,0,0);
  localparam logic [18:0] AUI = mk(0,0,0,0,0,0,2'b01,2'b01,2'b00,3'b100,2'b00,0,0);
  localparam logic [18:0] TRP = mk(0,0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0,1);

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mem_bus.mem_ready = 1'b1;
    opcode = 7'b0110011;
    funct3 = 3'b000;
    alu_zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (outs() !== ZERO) begin
        failures++;
        $display("FAIL reset_hold cyc%0d got=%h exp=%h", i, outs(), ZERO);
      end
      nxt();
    end
    reset = 1'b0;
    mem_bus.mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (outs() !== FW) begin
      failures++;
      $display("FAIL reset_release got=%h exp=%h", outs(), FW);
    end
    nxt();
  endtask

  task automatic test_rtype();
    logic [18:0] e [6];
    logic r [6];
    e = '{FW, FW, FR, DB, EXR, AWB};
    r = '{0, 0, 1, 0, 0, 0};
    opcode = 7'b0110011;
    for (int i = 0; i < 6; i++) begin
      mem_bus.mem_ready = r[i];
      @(negedge clk);
      checks++;
      if (outs() !== e[i]) begin
        failures++;
        $display("FAIL rtype cyc%0d got=%h exp=%h", i, outs(), e[i]);
      end
      nxt();
    end
  endtask

  task automatic test_imm_types();
    logic [18:0] e [11];
    logic [6:0] o [11];
    e = '{FR, DB, EXI, AWB, FR, DB, LU, FR, DB, AUI, AWB};
    o = '{7'b0010011, 7'b0010011, 7'b0010011, 7'b0010011,
          7'b0110111, 7'b0110111, 7'b0110111,
          7'b0010111, 7'b0010111, 7'b0010111, 7'b0010111};
    for (int i = 0; i < 11; i++) begin
      opcode = o[i];
      mem_bus.mem_ready = (e[i] == FR);
      @(negedge clk);
      checks++;
      if (outs() !== e[i]) begin
        failures++;
        $display("FAIL imm_types cyc%0d got=%h exp=%h", i, outs(), e[i]);
      end
      nxt();
    end
  endtask

  task automatic test_load_store();
    logic [18:0] e [10];
    logic r [10];
    logic [6:0] o [10];
    e = '{FR, DB, MAL, MR, MR, MWB, FR, DB, MAS, MW};
    r = '{1, 0, 0, 0, 1, 0, 1, 0, 0, 1};
    o = '{7'b0000011, 7'b0000011, 7'b0000011, 7'b0000011,
          7'b0000011, 7'b0000011,
          7'b0100011, 7'b0100011, 7'b0100011, 7'b0100011};
    for (int i = 0; i < 10; i++) begin
      opcode = o[i];
      mem_bus.mem_ready = r[i];
      @(negedge clk);
      checks++;
      if (outs() !== e[i]) begin
        failures++;
        $display("FAIL load_store cyc%0d got=%h exp=%h", i, outs(), e[i]);
      end
      nxt();
    end
  endtask

  task automatic test_branch();
    logic [2:0] f [3];
    logic z [3];
    logic [18:0] eb [3];
    logic [18:0] e [3];
    f  = '{3'b000, 3'b000, 3'b100};
    z  = '{1, 0, 0};
    eb = '{BRT, BRN, BRT};
    opcode = 7'b1100011;
    for (int c = 0; c < 3; c++) begin
      funct3 = f[c];
      alu_zero = z[c];
      e = '{FR, DB, eb[c]};
      for (int i = 0; i < 3; i++) begin
        // mem_ready stays high to show it is ignored after FETCH.
        mem_bus.mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (outs() !== e[i]) begin
          failures++;
          $display("FAIL branch case%0d cyc%0d got=%h exp=%h", c, i, outs(), e[i]);
        end
        nxt();
      end
    end
    alu_zero = 1'b0;
    funct3 = 3'b000;
  endtask

  task automatic test_jumps();
    logic [18:0] e [8];
    logic [6:0] o [8];
    e = '{FR, DJ, JL, AWB, FR, DB, JR, JRL};
    o = '{7'b1101111, 7'b1101111, 7'b1101111, 7'b1101111,
          7'b1100111, 7'b1100111, 7'b1100111, 7'b1100111};
    for (int i = 0; i < 8; i++) begin
      opcode = o[i];
      mem_bus.mem_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (outs() !== e[i]) begin
        failures++;
        $display("FAIL jumps cyc%0d got=%h exp=%h", i, outs(), e[i]);
      end
      nxt();
    end
  endtask

  task automatic test_reset_in_memread();
    logic [18:0] e [4];
    logic r [4];
    e = '{FR, DB, MAL, MR};
    r = '{1, 0, 0, 0};
    opcode = 7'b0000011;
    for (int i = 0; i < 4; i++) begin
      mem_bus.mem_ready = r[i];
      @(negedge clk);
      checks++;
      if (outs() !== e[i]) begin
        failures++;
        $display("FAIL rst_memread cyc%0d got=%h exp=%h", i, outs(), e[i]);
      end
      nxt();
    end
    // Still in MEMREAD: assert reset while the data arrives.
    reset = 1'b1;
    mem_bus.mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (outs() !== ZERO) begin
      failures++;
      $display("FAIL rst_memread_forced got=%h exp=%h", outs(), ZERO);
    end
    nxt();
    reset = 1'b0;
    mem_bus.mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (outs() !== FW) begin
      failures++;
      $display("FAIL rst_memread_fetch got=%h exp=%h", outs(), FW);
    end
    nxt();
  endtask

  task automatic test_trap();
    opcode = 7'b1111111;
    mem_bus.mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (outs() !== FR) begin
      failures++;
      $display("FAIL trap_fetch got=%h exp=%h", outs(), FR);
    end
    nxt();
    mem_bus.mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (outs() !== DB) begin
      failures++;
      $display("FAIL trap_decode got=%h exp=%h", outs(), DB);
    end
    nxt();
    for (int i = 0; i < 10; i++) begin
      mem_bus.mem_ready = i[0];
      @(negedge clk);
      checks++;
      if (outs() !== TRP) begin
        failures++;
        $display("FAIL trap_hold cyc%0d got=%h exp=%h", i, outs(), TRP);
      end
      nxt();
    end
    reset = 1'b1;
    nxt();
    reset = 1'b0;
    mem_bus.mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (outs() !== FW) begin
      failures++;
      $display("FAIL trap_recover got=%h exp=%h", outs(), FW);
    end
    nxt();
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_imm_types();
    test_load_store();
    test_branch();
    test_jumps();
    test_reset_in_memread();
    test_trap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
